ymem_stage: RTL and testbench

Multi-cycle data-memory access stage for the RISC-V datapath. Sits directly downstream of yEX: it takes the ALU result as the address and rd2 as store data, runs a request/acknowledge transaction against a wait-state data memory, and stalls the datapath for the whole transaction. It aligns loads (byte/half/word, signed and unsigned) and stores (lane replication plus byte enables), then hands writeback a registered load value with a valid pulse. It flags misaligned, illegal and timed-out accesses.

---
 rtl/ymem_pkg.sv | 38 +++
 rtl/ymem_align.sv | 59 +++++
 rtl/ymem_stage.sv | 149 ++++++++++++++
 tb/tb_ymem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ymem_pkg.sv
// Shared types and constants for the ymem data-memory access stage.
package ymem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10,
    S_FAULT  = 2'b11
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

  // Store payload presented to the data memory.
  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } lanes_t;

  function automatic logic f3_valid(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ymem_align.sv
// Combinational lane steering: store replication/byte enables, access checks,
// and load extraction with sign or zero extension.
module ymem_align
  import ymem_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic            rd,
  input  logic            wr,
  input  logic [XLEN-1:0] rd2,
  output lanes_t          lanes,
  output logic            misalign,
  output logic            illegal,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_val
);

  logic [XLEN-1:0] shifted;

  // Store lanes and access legality for the incoming request.
  always_comb begin
    lanes    = '0;
    misalign = 1'b0;
    illegal  = !f3_valid(funct3) || (rd && wr);
    case (funct3)
      F3_B, F3_BU: begin
        lanes.wdata = {4{rd2[7:0]}};
        lanes.be    = 4'b0001 << off;
      end
      F3_H, F3_HU: begin
        lanes.wdata = {2{rd2[15:0]}};
        lanes.be    = 4'b0011 << {off[1], 1'b0};
        misalign    = off[0];
      end
      F3_W: begin
        lanes.wdata = rd2;
        lanes.be    = 4'b1111;
        misalign    = (off != 2'b00);
      end
      default: ;
    endcase
    if (!wr) lanes.be = '0;
  end

  // Load extraction uses the offset/size captured at acceptance.
  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_val = {24'b0, shifted[7:0]};
      F3_H:    ld_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_val = {16'b0, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

endmodule

// File: rtl/ymem_stage.sv
// Multi-cycle data-memory access stage: req/ack transaction with stall,
// load/store alignment, and misalign/illegal/timeout fault reporting.
module ymem_stage
  import ymem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] exeOut,
  input  logic [XLEN-1:0] rd2,
  input  logic [4:0]      rdIn,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] memOut,
  output logic [4:0]      rdOut,
  output logic            wbValid,
  output logic            fault,
  output logic [1:0]      faultCode
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_rd;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;

  lanes_t          lanes;
  logic            misalign;
  logic            illegal;
  logic [XLEN-1:0] ld_val;

  logic            accept;
  logic            acc_fault;
  logic [1:0]      acc_code;

  ymem_align u_align (
    .funct3    (funct3),
    .off       (exeOut[1:0]),
    .rd        (MemRead),
    .wr        (MemWrite),
    .rd2       (rd2),
    .lanes     (lanes),
    .misalign  (misalign),
    .illegal   (illegal),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata),
    .ld_val    (ld_val)
  );

  always_comb begin
    accept    = (state != S_ACCESS) && start && (MemRead || MemWrite);
    stall     = accept || (state == S_ACCESS);
    acc_fault = illegal || misalign;
    acc_code  = illegal ? FLT_ILLEGAL : FLT_MISALIGN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_rd     <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      memOut    <= '0;
      rdOut     <= '0;
      wbValid   <= 1'b0;
      fault     <= 1'b0;
      faultCode <= FLT_NONE;
    end else begin
      done    <= 1'b0;
      fault   <= 1'b0;
      wbValid <= 1'b0;
      case (state)
        S_ACCESS: begin
          // Ack wins over a timeout reached in the same cycle.
          if (mem_ack) begin
            state     <= S_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            wbValid   <= is_rd;
            faultCode <= FLT_NONE;
            if (is_rd) begin
              memOut <= ld_val;
              rdOut  <= rd_q;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= S_FAULT;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b1;
            faultCode <= FLT_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (accept) begin
            is_rd <= MemRead;
            off_q <= exeOut[1:0];
            f3_q  <= funct3;
            rd_q  <= rdIn;
            if (acc_fault) begin
              state     <= S_FAULT;
              done      <= 1'b1;
              fault     <= 1'b1;
              faultCode <= acc_code;
            end else begin
              state     <= S_ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {exeOut[31:2], 2'b00};
              mem_wdata <= lanes.wdata;
              mem_be    <= lanes.be;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ymem_stage.sv
// Directed table-driven bench for ymem_stage (TIMEOUT=4) plus corner sequences.
module tb_ymem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] exeOut, rd2;
  logic [4:0]  rdIn;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, done, wbValid, fault;
  logic [31:0] memOut;
  logic [4:0]  rdOut;
  logic [1:0]  faultCode;

  int checks = 0;
  int failures = 0;

  ymem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .exeOut(exeOut), .rd2(rd2), .rdIn(rdIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .done(done), .memOut(memOut), .rdOut(rdOut), .wbValid(wbValid),
    .fault(fault), .faultCode(faultCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rdin;
    logic [31:0] rdata;
    int          k;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] memout;
    logic [4:0]  rdout;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rdin, input logic [31:0] rdata, input int k,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] memout, input logic [4:0] rdout,
                              input logic flt, input logic [1:0] code);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdin = rdin;
    v.rdata = rdata; v.k = k; v.be = be; v.wdata = wdata; v.memout = memout;
    v.rdout = rdout; v.flt = flt; v.code = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdin);
    start = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3;
    exeOut = addr; rd2 = sdata; rdIn = rdin;
  endtask

  task automatic idle_inputs();
    start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    present(v.rd, v.wr, v.f3, v.addr, v.sdata, v.rdin);
    #1 chk($sformatf("v%0d_stall0", idx), 32'(stall), 32'd1);
    tick();
    idle_inputs();
    if (v.flt) begin
      chk($sformatf("v%0d_req", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d_fault", idx), 32'(fault), 32'd1);
      chk($sformatf("v%0d_code", idx), 32'(faultCode), 32'(v.code));
      chk($sformatf("v%0d_wb", idx), 32'(wbValid), 32'd0);
    end else begin
      chk($sformatf("v%0d_req", idx), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.wr));
      chk($sformatf("v%0d_addr", idx), mem_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.be));
      if (v.wr) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
      for (int c = 1; c < v.k; c++) begin
        chk($sformatf("v%0d_stall_c%0d", idx, c), 32'(stall), 32'd1);
        tick();
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      chk($sformatf("v%0d_req_ack", idx), 32'(mem_req), 32'd1);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d_fault", idx), 32'(fault), 32'd0);
      chk($sformatf("v%0d_code", idx), 32'(faultCode), 32'd0);
      chk($sformatf("v%0d_wb", idx), 32'(wbValid), 32'(v.rd));
      chk($sformatf("v%0d_req_off", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d_stall_done", idx), 32'(stall), 32'd0);
    end
    chk($sformatf("v%0d_memout", idx), memOut, v.memout);
    chk($sformatf("v%0d_rdout", idx), 32'(rdOut), 32'(v.rdout));
    tick();
    chk($sformatf("v%0d_done_off", idx), 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd wr f3      addr          sdata         rd  rdata         k  be       wdata         memout        rdout flt code
    vecs[0]  = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        5,  32'hDEADBEEF, 3, 4'b0000, 32'h0,        32'hDEADBEEF, 5,    0,  2'b00);
    vecs[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        6,  32'h80FF1234, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 6,    0,  2'b00);
    vecs[2]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        7,  32'h80FF1234, 2, 4'b0000, 32'h0,        32'h00000080, 7,    0,  2'b00);
    vecs[3]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,        8,  32'h80FF1234, 1, 4'b0000, 32'h0,        32'hFFFF80FF, 8,    0,  2'b00);
    vecs[4]  = mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,        9,  32'h80FF1234, 1, 4'b0000, 32'h0,        32'h000080FF, 9,    0,  2'b00);
    vecs[5]  = mk(0, 1, 3'b000, 32'h0000_0002, 32'h000000AB, 10, 32'h5555AAAA, 2, 4'b0100, 32'hABABABAB, 32'h000080FF, 9,    0,  2'b00);
    vecs[6]  = mk(0, 1, 3'b001, 32'h0000_0006, 32'h1234CAFE, 11, 32'h0,        1, 4'b1100, 32'hCAFECAFE, 32'h000080FF, 9,    0,  2'b00);
    vecs[7]  = mk(0, 1, 3'b010, 32'h0000_0008, 32'h11223344, 11, 32'h0,        1, 4'b1111, 32'h11223344, 32'h000080FF, 9,    0,  2'b00);
    vecs[8]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        12, 32'h0,        1, 4'b0000, 32'h0,        32'h000080FF, 9,    1,  2'b01);
    vecs[9]  = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,        12, 32'h0,        1, 4'b0000, 32'h0,        32'h000080FF, 9,    1,  2'b11);
    vecs[10] = mk(1, 0, 3'b001, 32'h0000_0101, 32'h0,        12, 32'h0,        1, 4'b0000, 32'h0,        32'h000080FF, 9,    1,  2'b01);
    vecs[11] = mk(1, 1, 3'b010, 32'h0000_0000, 32'h0,        12, 32'h0,        1, 4'b0000, 32'h0,        32'h000080FF, 9,    1,  2'b11);
    vecs[12] = mk(0, 1, 3'b010, 32'h0000_0002, 32'h0,        12, 32'h0,        1, 4'b0000, 32'h0,        32'h000080FF, 9,    1,  2'b01);
    vecs[13] = mk(1, 0, 3'b000, 32'h0000_0000, 32'h0,        12, 32'h0000007F, 1, 4'b0000, 32'h0,        32'h0000007F, 12,   0,  2'b00);

    rst = 1'b1; idle_inputs(); funct3 = 3'b0; exeOut = '0; rd2 = '0; rdIn = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memout", memOut, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_code", 32'(faultCode), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // start with neither MemRead nor MemWrite is ignored
    start = 1'b1;
    #1 chk("noop_stall", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    chk("noop_req", 32'(mem_req), 32'd0);
    chk("noop_done", 32'(done), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // timeout: four ACCESS cycles without ack
    present(1, 0, 3'b010, 32'h20, 32'h0, 3);
    tick(); idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_req_c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("to_stall_c%0d", c), 32'(stall), 32'd1);
      tick();
    end
    chk("to_req_off", 32'(mem_req), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(faultCode), 32'd2);
    chk("to_wb", 32'(wbValid), 32'd0);
    tick();
    chk("to_code_held", 32'(faultCode), 32'd2);
    chk("to_done_off", 32'(done), 32'd0);

    // ack on the last allowed ACCESS cycle
    present(1, 0, 3'b010, 32'h24, 32'h0, 3);
    tick(); idle_inputs();
    for (int c = 1; c <= 3; c++) tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    chk("ta_req", 32'(mem_req), 32'd1);
    tick(); mem_ack = 1'b0;
    chk("ta_done", 32'(done), 32'd1);
    chk("ta_fault", 32'(fault), 32'd0);
    chk("ta_code", 32'(faultCode), 32'd0);
    chk("ta_memout", memOut, 32'h0BADF00D);
    chk("ta_rdout", 32'(rdOut), 32'd3);
    tick();

    // back-to-back: new start in the DONE cycle
    present(1, 0, 3'b010, 32'h40, 32'h0, 1);
    tick(); idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick(); mem_ack = 1'b0;
    present(1, 0, 3'b010, 32'h44, 32'h0, 2);
    #1;
    chk("bb_done1", 32'(done), 32'd1);
    chk("bb_memout1", memOut, 32'h11111111);
    chk("bb_stall", 32'(stall), 32'd1);
    tick(); idle_inputs();
    chk("bb_req2", 32'(mem_req), 32'd1);
    chk("bb_addr2", mem_addr, 32'h44);
    chk("bb_done_off", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    tick(); mem_ack = 1'b0;
    chk("bb_done2", 32'(done), 32'd1);
    chk("bb_memout2", memOut, 32'h22222222);
    chk("bb_rdout2", 32'(rdOut), 32'd2);
    tick();

    // asynchronous reset in the middle of ACCESS
    present(1, 0, 3'b010, 32'h80, 32'h0, 4);
    tick(); idle_inputs();
    tick();
    chk("mr_req_pre", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("mr_done_after", 32'(done), 32'd0);
    present(1, 0, 3'b010, 32'h84, 32'h0, 13);
    tick(); idle_inputs();
    chk("mr_req_new", 32'(mem_req), 32'd1);
    chk("mr_addr_new", mem_addr, 32'h84);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEBABE;
    tick(); mem_ack = 1'b0;
    chk("mr_done_new", 32'(done), 32'd1);
    chk("mr_memout_new", memOut, 32'hCAFEBABE);
    chk("mr_rdout_new", 32'(rdOut), 32'd13);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
